// File: rtl/split_eval_pkg.sv
// Shared types and constants for the serial split-constraint evaluator.
//   state_e    : frame FSM states (IDLE, ACCUM, DONE)
//   MODE_*     : verdict mode encodings
//   DEF_*      : default widths / frame size
package split_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned MODE_TRUE  = 0;
  localparam int unsigned MODE_SUM   = 1;
  localparam int unsigned MODE_RANGE = 2;

  localparam int unsigned DEF_NUM_VARS = 35;
  localparam int unsigned DEF_VAR_W    = 16;
  localparam int unsigned DEF_ACC_W    = 24;

endpackage

// File: rtl/split_eval_acc.sv
// Frame sum accumulator with sticky overflow.
// Build option: SPLIT_EVAL_SAT_EN -- when defined the sum saturates at all-ones
// and stays there for the rest of the frame; otherwise it wraps.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : zero sum and overflow (end of frame)
//   load       : start a new sum with din (first beat)
//   add        : add din to the running sum
//   din        : zero-extended variable value
//   acc_nxt_c  : sum value taking effect at the next edge
//   ovf_nxt_c  : overflow flag taking effect at the next edge
module split_eval_acc #(
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             add,
  input  logic [ACC_W-1:0] din,
  output logic [ACC_W-1:0] acc_nxt_c,
  output logic             ovf_nxt_c
);

  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [ACC_W:0]   sum;

  // Next sum; bit ACC_W of the widened add is the carry-out
  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, din};
    acc_nxt_c = acc_q;
    ovf_nxt_c = ovf_q;
    if (clr) begin
      acc_nxt_c = '0;
      ovf_nxt_c = 1'b0;
    end else if (load) begin
      acc_nxt_c = din;
      ovf_nxt_c = 1'b0;
    end else if (add) begin
      ovf_nxt_c = ovf_q | sum[ACC_W];
`ifdef SPLIT_EVAL_SAT_EN
      acc_nxt_c = (ovf_q | sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
      acc_nxt_c = sum[ACC_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_nxt_c;
      ovf_q <= ovf_nxt_c;
    end
  end

endmodule

// File: rtl/split_stream_eval.sv
// Serial split-constraint evaluator: counts, sums and range-checks one frame of
// variables arriving on a valid/ready stream, then emits one verdict per frame.
// Build option: SPLIT_EVAL_SAT_EN (saturating sum, see split_eval_acc).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   cfg_limit            : sum limit (MODE_SUM), sampled on the first beat
//   cfg_bound            : per-beat bound (MODE_RANGE), qualified with in_data
//   in_valid/in_ready    : variable beat handshake
//   in_data, in_last     : variable value, final beat of frame
//   out_valid/out_ready  : verdict handshake
//   out_x                : constraint satisfied
//   out_err              : beat count differed from NUM_VARS
module split_stream_eval
  import split_eval_pkg::*;
#(
  parameter int unsigned NUM_VARS = DEF_NUM_VARS,
  parameter int unsigned VAR_W    = DEF_VAR_W,
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter int unsigned MODE     = MODE_TRUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] cfg_limit,
  input  logic [VAR_W-1:0] cfg_bound,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAR_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_x,
  output logic             out_err
);

  // Count saturates at NUM_VARS+1 so any surplus beats still read as an error
  localparam int unsigned CNT_W = $clog2(NUM_VARS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_VARS + 1);
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(NUM_VARS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ok_q, ok_d;
  logic [ACC_W-1:0] limit_q, limit_d;
  logic             in_ready_d, out_valid_d, out_x_d, out_err_d;
  logic             acc_clr, acc_load, acc_add;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;
  logic [ACC_W-1:0] din_ext;
  logic             beat, bound_ok, err_n, pass_n;

  assign beat    = in_valid & in_ready;
  assign din_ext = ACC_W'(in_data);

  split_eval_acc #(.ACC_W(ACC_W)) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (acc_clr),
    .load      (acc_load),
    .add       (acc_add),
    .din       (din_ext),
    .acc_nxt_c (acc_nxt),
    .ovf_nxt_c (ovf_nxt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (beat) state_d = in_last ? DONE : ACCUM;
      ACCUM:   if (beat && in_last) state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath controls and next values of the registered outputs; the verdict
  // is computed from next-state values so it is valid the cycle after in_last
  always_comb begin
    acc_clr     = 1'b0;
    acc_load    = 1'b0;
    acc_add     = 1'b0;
    count_d     = count_q;
    ok_d        = ok_q;
    limit_d     = limit_q;
    out_x_d     = out_x;
    out_err_d   = out_err;
    err_n       = 1'b0;
    pass_n      = 1'b1;
    bound_ok    = (MODE != MODE_RANGE) || (in_data <= cfg_bound);

    unique case (state_q)
      IDLE: if (beat) begin
        limit_d  = cfg_limit;
        acc_load = 1'b1;
        ok_d     = bound_ok;
        count_d  = CNT_W'(1);
      end
      ACCUM: if (beat) begin
        acc_add = 1'b1;
        ok_d    = ok_q & bound_ok;
        if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
      end
      DONE: if (out_valid && out_ready) begin
        acc_clr = 1'b1;
        count_d = '0;
        ok_d    = 1'b1;
      end
      default: ;
    endcase

    if (MODE == MODE_SUM)        pass_n = !ovf_nxt && (acc_nxt <= limit_d);
    else if (MODE == MODE_RANGE) pass_n = ok_d;
    else                         pass_n = 1'b1;
    err_n = (count_d != CNT_EXP);

    in_ready_d  = (state_d != DONE);
    out_valid_d = (state_d == DONE);
    if (state_q != DONE && state_d == DONE) begin
      out_err_d = err_n;
      out_x_d   = !err_n && pass_n;
    end else if (state_d != DONE) begin
      out_err_d = 1'b0;
      out_x_d   = 1'b0;
    end
  end

  // Counter, flags and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      ok_q      <= 1'b1;
      limit_q   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_x     <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      count_q   <= count_d;
      ok_q      <= ok_d;
      limit_q   <= limit_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_x     <= out_x_d;
      out_err   <= out_err_d;
    end
  end

endmodule
